// File: rtl/mult_accumulator.sv
// Accumulates a stream of unsigned multiplier products into groups and emits one
// saturating sum plus beat count per group through a single-entry result register.
module mult_accumulator #(
    parameter int SIZE      = 32,
    parameter int ACC_GUARD = 8,
    parameter int CNT_W     = 16,
    parameter int ACC_W     = 2*SIZE + ACC_GUARD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*SIZE-1:0] in_prod,
    input  logic              in_clear,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    // state  | meaning
    // IDLE   | no group open; next accepted beat starts from zero
    // ACCUM  | group open; acc/cnt/ovf hold its running values
    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             r_state, w_state_next;
    logic [ACC_W-1:0]   r_acc, w_acc_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               r_ovf, w_ovf_next;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_acc;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_ovf;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_fresh;
    logic [ACC_W-1:0]   w_base;
    logic [ACC_W:0]     w_sum;
    logic               w_grp_ovf;
    logic [ACC_W-1:0]   w_grp_acc;
    logic [CNT_W-1:0]   w_grp_cnt;

    assign w_in_ready = rst_n && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_fresh    = (r_state == S_IDLE) || in_clear;
    assign w_base     = w_fresh ? '0 : r_acc;
    assign w_sum      = {1'b0, w_base} + {{(ACC_GUARD+1){1'b0}}, in_prod};
    // Sticky flag forces the saturated value even when a later beat adds zero.
    assign w_grp_ovf  = (!w_fresh && r_ovf) || w_sum[ACC_W];
    assign w_grp_acc  = w_grp_ovf ? ACC_MAX : w_sum[ACC_W-1:0];
    assign w_grp_cnt  = w_fresh ? CNT_W'(1) :
                        ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1));

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_ovf_next   = r_ovf;
        if (w_accept) begin
            if (in_last) begin
                w_state_next = S_IDLE;
                w_acc_next   = '0;
                w_cnt_next   = '0;
                w_ovf_next   = 1'b0;
            end else begin
                w_state_next = S_ACCUM;
                w_acc_next   = w_grp_acc;
                w_cnt_next   = w_grp_cnt;
                w_ovf_next   = w_grp_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_ovf   <= w_ovf_next;
        end
    end

    // A load can only happen when the register is empty or draining this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_accept && in_last) begin
            r_out_valid <= 1'b1;
            r_out_acc   <= w_grp_acc;
            r_out_count <= w_grp_cnt;
            r_out_ovf   <= w_grp_ovf;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule
